art_mc_fsm: RTL and testbench

ART_MC_FSM -- requirements
Module: art_mc_fsm

---
 rtl/art_pkg.sv | 15 +
 rtl/art_mc_fsm_if.sv | 18 +
 rtl/art_rr_arb.sv | 20 ++
 rtl/art_mc_fsm.sv | 74 +++++++
 tb/tb_art_mc_fsm.sv | 188 ++++++++++++++++++
 5 files changed

// File: rtl/art_pkg.sv
// art_pkg: state encodings, permission-check type constants and the permission check itself
package art_pkg;
    typedef enum logic [2:0] {
        IdleSt     = 3'b001,
        WaitMemAck = 3'b010,
        FaultServ  = 3'b100
    } state_t;
    localparam logic ART_I_TYPE = 1'b0;
    localparam logic ART_D_TYPE = 1'b1;
    function automatic logic perm_fault(input logic d_type, wr, r, x, u, p, priv, i);
        logic mode;
        mode = (priv & ~p) | (~priv & ~u);
        return d_type ? (wr & r) | mode : ~x | mode | i;
    endfunction
endpackage

// File: rtl/art_mc_fsm_if.sv
// art_mc_fsm_if: per-channel request/attribute bus plus memory and fault handshakes
interface art_mc_fsm_if #(parameter int NUM_CH = 2, parameter int CH_W = 1, parameter int TMO_W = 8);
    logic [NUM_CH-1:0] art_req, art_miss, iflag, rflag, xflag, uflag, pflag, ctl_priv, wr_op;
    logic [NUM_CH-1:0] serving, done;
    logic              mem_req, mem_ack, miss_fault, perm_fault, tmo_fault, fault_ack, fault_strobe;
    logic [CH_W-1:0]   mem_ch, fault_ch;
    logic [TMO_W-1:0]  tmo_cycles;
    modport master (
        output art_req, art_miss, iflag, rflag, xflag, uflag, pflag, ctl_priv, wr_op,
        output mem_ack, fault_ack, tmo_cycles,
        input  serving, done, mem_req, mem_ch, miss_fault, perm_fault, tmo_fault, fault_ch, fault_strobe
    );
    modport slave (
        input  art_req, art_miss, iflag, rflag, xflag, uflag, pflag, ctl_priv, wr_op,
        input  mem_ack, fault_ack, tmo_cycles,
        output serving, done, mem_req, mem_ch, miss_fault, perm_fault, tmo_fault, fault_ch, fault_strobe
    );
endinterface

// File: rtl/art_rr_arb.sv
// art_rr_arb: round-robin selector starting one past last_ch
module art_rr_arb #(parameter int NUM_CH = 2, parameter int CH_W = 1) (
    input  logic [NUM_CH-1:0] req,
    input  logic [CH_W-1:0]   last_ch,
    output logic [NUM_CH-1:0] gnt,
    output logic [CH_W-1:0]   idx
);
    // walk from farthest to nearest so the closest requester after last_ch wins
    always_comb begin
        gnt = '0;
        idx = '0;
        for (int k = NUM_CH; k >= 1; k--)
            for (int i = 0; i < NUM_CH; i++)
                if (req[i] && i == (int'(last_ch) + k) % NUM_CH) begin
                    gnt = '0;
                    gnt[i] = 1'b1;
                    idx = CH_W'(i);
                end
    end
endmodule

// File: rtl/art_mc_fsm.sv
// art_mc_fsm: multi-channel lookup controller (arbitrate, permission check, memory request, fault service)
// Optional memory-ack timeout enabled by macro ART_MC_TMO_EN.
module art_mc_fsm
    import art_pkg::*;
#(
    parameter int                NUM_CH      = 2,
    parameter logic [NUM_CH-1:0] D_TYPE_MASK = 2'b10,
    parameter int                CH_W        = 1,
    parameter int                TMO_W       = 8
) (
    input logic        Clk,
    input logic        Reset_n,
    art_mc_fsm_if.slave bus
);
    state_t            state, state_nxt;
    logic [CH_W-1:0]   cur_ch, last_ch, sel;
    logic [NUM_CH-1:0] gnt;
    logic              mem_req, accept, sel_miss, sel_perm, tmo_hit;

    art_rr_arb #(.NUM_CH(NUM_CH), .CH_W(CH_W)) u_arb (.req(bus.art_req), .last_ch, .gnt, .idx(sel));

    assign accept   = state == IdleSt && |bus.art_req;
    assign sel_miss = bus.art_miss[sel];
    assign sel_perm = perm_fault(D_TYPE_MASK[sel] == ART_D_TYPE, bus.wr_op[sel], bus.rflag[sel], bus.xflag[sel],
                                 bus.uflag[sel], bus.pflag[sel], bus.ctl_priv[sel], bus.iflag[sel]);

`ifdef ART_MC_TMO_EN
    logic [TMO_W-1:0] tmo_cnt, tmo_inc;
    assign tmo_inc = tmo_cnt + 1'b1;
    // an ack in the same cycle takes precedence over the timeout
    assign tmo_hit = state == WaitMemAck && !bus.mem_ack && bus.tmo_cycles != '0 && tmo_inc == bus.tmo_cycles;
    always_ff @(posedge Clk)
        tmo_cnt <= (!Reset_n || state != WaitMemAck || bus.mem_ack) ? '0 : tmo_inc;
`else
    logic unused_tmo;
    assign unused_tmo = ^bus.tmo_cycles;
    assign tmo_hit = 1'b0;
`endif

    always_comb begin
        state_nxt = IdleSt;
        case (state)
            IdleSt:     state_nxt = !accept ? IdleSt : (sel_miss || sel_perm) ? FaultServ : WaitMemAck;
            WaitMemAck: state_nxt = bus.mem_ack ? IdleSt : tmo_hit ? FaultServ : WaitMemAck;
            FaultServ:  state_nxt = bus.fault_ack ? IdleSt : FaultServ;
            default:    state_nxt = IdleSt;
        endcase
        bus.serving      = (Reset_n && accept) ? gnt : '0;
        bus.miss_fault   = Reset_n && accept && sel_miss;
        bus.perm_fault   = Reset_n && accept && !sel_miss && sel_perm;
        bus.tmo_fault    = Reset_n && tmo_hit;
        bus.done         = (Reset_n && state == WaitMemAck && bus.mem_ack) ? NUM_CH'(1) << cur_ch : '0;
        bus.fault_strobe = Reset_n && state == FaultServ && bus.fault_ack;
        bus.fault_ch     = accept ? sel : cur_ch;
        bus.mem_req      = mem_req;
        bus.mem_ch       = cur_ch;
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state   <= IdleSt;
            mem_req <= 1'b0;
            cur_ch  <= '0;
            last_ch <= CH_W'(NUM_CH - 1);
        end else begin
            state   <= state_nxt;
            mem_req <= state_nxt == WaitMemAck;
            if (accept) begin
                cur_ch  <= sel;
                last_ch <= sel;
            end
        end
    end
endmodule

// File: tb/tb_art_mc_fsm.sv
// tb_art_mc_fsm: directed stimulus with an event scoreboard checked by an independent monitor
module tb_art_mc_fsm;
    typedef struct packed {
        logic [1:0] serving;
        logic [1:0] done;
        logic       miss, perm, tmo, strobe, fault_ch, mem_req;
    } ev_t;

    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    ev_t  q[$];
    ev_t  act, exp_ev;

    always #5 clk = ~clk;

    art_mc_fsm_if #(.NUM_CH(2), .CH_W(1), .TMO_W(8)) bus ();
    art_mc_fsm #(.NUM_CH(2), .D_TYPE_MASK(2'b10), .CH_W(1), .TMO_W(8)) dut (.Clk(clk), .Reset_n(rst_n), .bus(bus.slave));

    function automatic ev_t mk(logic [1:0] s, logic [1:0] d, logic mi, logic pe, logic tm, logic st, logic fc, logic mr);
        return {s, d, mi, pe, tm, st, fc, mr};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] got, logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    // every pulse-bearing cycle must match the next queued expectation
    always @(negedge clk) begin
        act = {bus.serving, bus.done, bus.miss_fault, bus.perm_fault, bus.tmo_fault, bus.fault_strobe, bus.fault_ch, bus.mem_req};
        if (|act.serving || |act.done || act.miss || act.perm || act.tmo || act.strobe) begin
            total++;
            if (q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_event: got %b expected none", act);
            end else begin
                exp_ev = q.pop_front();
                if (act !== exp_ev) begin
                    bad++;
                    $display("FAIL event: got %b expected %b", act, exp_ev);
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        bus.art_req = 2'b11; bus.art_miss = 2'b00; bus.iflag = 2'b00; bus.rflag = 2'b00;
        bus.xflag = 2'b11; bus.uflag = 2'b11; bus.pflag = 2'b11; bus.ctl_priv = 2'b00; bus.wr_op = 2'b00;
        bus.mem_ack = 1'b1; bus.fault_ack = 1'b1; bus.tmo_cycles = 8'd0;
        step();
        step();
        chk("reset_serving", 32'(bus.serving), 32'h0);
        chk("reset_pulses", {bus.done, bus.miss_fault, bus.perm_fault, bus.tmo_fault, bus.fault_strobe}, 32'h0);
        chk("reset_mem_req", 32'(bus.mem_req), 32'h0);
        bus.mem_ack = 1'b0; bus.fault_ack = 1'b0; rst_n = 1'b1;
        // round robin: ch0 first, then ch1
        q.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        step();
        chk("mem_req_latency", 32'(bus.mem_req), 32'h1);
        chk("mem_ch0", 32'(bus.mem_ch), 32'h0);
        bus.mem_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 1));
        step();
        bus.mem_ack = 1'b0; bus.art_req = 2'b10;
        q.push_back(mk(2'b10, 2'b00, 0, 0, 0, 0, 1, 0));
        step();
        chk("mem_ch1", 32'(bus.mem_ch), 32'h1);
        bus.fault_ack = 1'b1;
        step();
        bus.fault_ack = 1'b0;
        step();
        bus.mem_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b10, 0, 0, 0, 0, 1, 1));
        step();
        bus.mem_ack = 1'b0; bus.art_req = 2'b00;
        step();
        // ch1 D-type write to read-only: perm fault, stray mem ack ignored
        bus.rflag = 2'b10; bus.wr_op = 2'b10; bus.art_req = 2'b10;
        q.push_back(mk(2'b10, 2'b00, 0, 1, 0, 0, 1, 0));
        step();
        chk("perm_no_mem_req", 32'(bus.mem_req), 32'h0);
        bus.mem_ack = 1'b1;
        step();
        chk("fault_no_mem_req", 32'(bus.mem_req), 32'h0);
        bus.mem_ack = 1'b0; bus.fault_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 1, 0));
        step();
        bus.fault_ack = 1'b0; bus.art_req = 2'b00; bus.rflag = 2'b00; bus.wr_op = 2'b00;
        step();
        // ch0 I-type miss with X=0: miss only
        bus.art_miss = 2'b01; bus.xflag = 2'b10; bus.art_req = 2'b01;
        q.push_back(mk(2'b01, 2'b00, 1, 0, 0, 0, 0, 0));
        step();
        bus.fault_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
        step();
        bus.fault_ack = 1'b0; bus.art_req = 2'b00; bus.art_miss = 2'b00; bus.xflag = 2'b11;
        step();
        // ch0 privileged without P: perm fault
        bus.ctl_priv = 2'b01; bus.pflag = 2'b10; bus.art_req = 2'b01;
        q.push_back(mk(2'b01, 2'b00, 0, 1, 0, 0, 0, 0));
        step();
        bus.fault_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
        step();
        bus.fault_ack = 1'b0; bus.art_req = 2'b00; bus.ctl_priv = 2'b00; bus.pflag = 2'b11;
        step();
        // ch1 D-type ignores X and I flags
        bus.xflag = 2'b01; bus.iflag = 2'b10; bus.art_req = 2'b10;
        q.push_back(mk(2'b10, 2'b00, 0, 0, 0, 0, 1, 0));
        step();
        chk("dtype_mem_req", 32'(bus.mem_req), 32'h1);
        chk("dtype_mem_ch", 32'(bus.mem_ch), 32'h1);
        bus.mem_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b10, 0, 0, 0, 0, 1, 1));
        step();
        bus.mem_ack = 1'b0; bus.art_req = 2'b00; bus.xflag = 2'b11; bus.iflag = 2'b00;
        step();
        // ch0 I-type with I flag set: perm fault
        bus.iflag = 2'b01; bus.art_req = 2'b01;
        q.push_back(mk(2'b01, 2'b00, 0, 1, 0, 0, 0, 0));
        step();
        bus.fault_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
        step();
        bus.fault_ack = 1'b0; bus.art_req = 2'b00; bus.iflag = 2'b00;
        step();
`ifdef ART_MC_TMO_EN
        // timeout after 4 cycles of mem_req, late ack ignored
        bus.tmo_cycles = 8'd4; bus.art_req = 2'b01;
        q.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        step();
        for (int i = 1; i <= 4; i++) begin
            chk("tmo_mem_req_high", 32'(bus.mem_req), 32'h1);
            if (i == 4) q.push_back(mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 1));
            step();
        end
        chk("tmo_mem_req_low", 32'(bus.mem_req), 32'h0);
        bus.mem_ack = 1'b1;
        step();
        bus.mem_ack = 1'b0; bus.fault_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 0));
        step();
        bus.fault_ack = 1'b0; bus.art_req = 2'b00;
        step();
        // ack coinciding with timeout completes normally
        bus.tmo_cycles = 8'd2; bus.art_req = 2'b01;
        q.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        step();
        step();
        bus.mem_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 1));
        step();
        bus.mem_ack = 1'b0; bus.art_req = 2'b00; bus.tmo_cycles = 8'd0;
        step();
`endif
        // reset during WaitMemAck abandons the transaction
        bus.art_req = 2'b01;
        q.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        step();
        rst_n = 1'b0; bus.mem_ack = 1'b1; bus.art_req = 2'b11;
        step();
        chk("reset_clears_mem_req", 32'(bus.mem_req), 32'h0);
        rst_n = 1'b1; bus.mem_ack = 1'b0;
        q.push_back(mk(2'b01, 2'b00, 0, 0, 0, 0, 0, 0));
        step();
        bus.mem_ack = 1'b1;
        q.push_back(mk(2'b00, 2'b01, 0, 0, 0, 0, 0, 1));
        step();
        bus.mem_ack = 1'b0; bus.art_req = 2'b00;
        step();
        step();
        chk("scoreboard_drained", 32'(q.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
